// File: rtl/mux2_pair_serializer_if.sv
// Operand, mux-bank and output-stream signals of mux2_pair_serializer.
// The slave modport is the controller's view; master is the surrounding logic plus bank.
interface mux2_pair_serializer_if #(
  parameter int W = 8
);
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] MUX_A;
  logic [W-1:0] MUX_B;
  logic         S;
  logic [W-1:0] Y;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] OUT_DATA;
  logic         OUT_LAST;

  modport master (
    output IN_VALID, A, B, Y, OUT_READY,
    input  IN_READY, MUX_A, MUX_B, S, OUT_VALID, OUT_DATA, OUT_LAST
  );

  modport slave (
    input  IN_VALID, A, B, Y, OUT_READY,
    output IN_READY, MUX_A, MUX_B, S, OUT_VALID, OUT_DATA, OUT_LAST
  );
endinterface

// File: rtl/mux2_pair_serializer.sv
// Serializes an A/B pair through an inverting 2:1 mux bank; first word 2 cycles after accept (3 with MUX2_PAIR_SETTLE2_EN).
// Output holds word/last under backpressure; one pair in flight, IN_READY only when idle.
module mux2_pair_serializer #(
  parameter int W = 8
) (
  input logic                 CLK,
  input logic                 R,
  mux2_pair_serializer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE_A = 3'd1,
    EMIT_A   = 3'd2,
    SETTLE_B = 3'd3,
    EMIT_B   = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_mux_a;
  logic [W-1:0] r_mux_b;
  logic [W-1:0] r_out_data;
  logic         r_s;
  logic         w_s_nxt;
  logic         w_accept;
  logic         w_capture;
  logic         w_settle_done;

`ifdef MUX2_PAIR_SETTLE2_EN
  // Second settle cycle is marked by the counter having toggled once.
  logic r_settle_cnt;

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_settle_cnt <= 1'b0;
    end else if (r_state == SETTLE_A || r_state == SETTLE_B) begin
      r_settle_cnt <= ~r_settle_cnt;
    end else begin
      r_settle_cnt <= 1'b0;
    end
  end

  assign w_settle_done = r_settle_cnt;
`else
  assign w_settle_done = 1'b1;
`endif

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.IN_VALID) begin
          w_accept    = 1'b1;
          w_s_nxt     = 1'b0;
          w_state_nxt = SETTLE_A;
        end
      end
      SETTLE_A: begin
        if (w_settle_done) begin
          w_capture   = 1'b1;
          w_state_nxt = EMIT_A;
        end
      end
      EMIT_A: begin
        if (bus.OUT_READY) begin
          w_s_nxt     = 1'b1;
          w_state_nxt = SETTLE_B;
        end
      end
      SETTLE_B: begin
        if (w_settle_done) begin
          w_capture   = 1'b1;
          w_state_nxt = EMIT_B;
        end
      end
      EMIT_B: begin
        if (bus.OUT_READY) begin
          w_s_nxt     = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_s_nxt     = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Y arrives inverted from the bank; undo it at capture.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_mux_a    <= '0;
      r_mux_b    <= '0;
      r_s        <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_s <= w_s_nxt;
      if (w_accept) begin
        r_mux_a <= bus.A;
        r_mux_b <= bus.B;
      end
      if (w_capture) begin
        r_out_data <= ~bus.Y;
      end
    end
  end

  assign bus.IN_READY  = (r_state == IDLE);
  assign bus.OUT_VALID = (r_state == EMIT_A) || (r_state == EMIT_B);
  assign bus.OUT_LAST  = (r_state == EMIT_B);
  assign bus.MUX_A     = r_mux_a;
  assign bus.MUX_B     = r_mux_b;
  assign bus.S         = r_s;
  assign bus.OUT_DATA  = r_out_data;

endmodule

// File: tb/tb_mux2_pair_serializer.sv
// Directed and randomized bench for mux2_pair_serializer with an inverting mux-bank model on Y.
module tb_mux2_pair_serializer;

`ifdef MUX2_PAIR_SETTLE2_EN
  localparam int SETTLE = 2;
`else
  localparam int SETTLE = 1;
`endif
  localparam int PERIOD = 2 * SETTLE + 3;

  logic CLK = 1'b0;
  logic R   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic       y_force     = 1'b0;
  logic [7:0] y_force_val = 8'h00;
  logic       glitch_en   = 1'b0;
  logic [7:0] y_rand      = 8'h00;

  mux2_pair_serializer_if #(.W(8)) bus ();

  mux2_pair_serializer #(.W(8)) dut (
    .CLK (CLK),
    .R   (R),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Inverting bank; extra perturbation only where Y is not sampled.
  assign bus.Y = y_force ? y_force_val :
                 (glitch_en && (bus.OUT_VALID || bus.IN_READY)) ? y_rand :
                 ~(bus.S ? bus.MUX_B : bus.MUX_A);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Run the settle phase; with two-cycle settle, Y is wrong during the first cycle.
  task automatic settle();
    for (int k = 0; k < SETTLE; k++) begin
      if (k < SETTLE - 1) begin
        y_force     = 1'b1;
        y_force_val = 8'h5A;
      end else begin
        y_force = 1'b0;
      end
      step();
    end
    y_force = 1'b0;
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    bus.A        = a;
    bus.B        = b;
    bus.IN_VALID = 1'b1;
    step();
    bus.IN_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got_w[$];
    logic       got_l[$];
    int         acc_cyc[$];
    logic [8:0] q[$];
    logic [8:0] e;
    logic [7:0] exp_w[4];
    logic       exp_l[4];
    logic [7:0] acc_a, acc_b, prev_data;
    logic       prev_last, prev_hold, have_acc, hs_in;

    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.A         = 8'h00;
    bus.B         = 8'h00;

    // Reset and idle
    #2;
    chk("rst_in_ready", bus.IN_READY, 1);
    chk("rst_out_valid", bus.OUT_VALID, 0);
    chk("rst_s", bus.S, 0);
    chk("rst_mux_a", bus.MUX_A, 0);
    chk("rst_out_data", bus.OUT_DATA, 0);
    @(negedge CLK);
    @(negedge CLK);
    R = 1'b1;
    y_force     = 1'b1;
    y_force_val = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_out_data", bus.OUT_DATA, 0);
      chk("idle_in_ready", bus.IN_READY, 1);
      chk("idle_out_valid", bus.OUT_VALID, 0);
      chk("idle_s", bus.S, 0);
    end
    y_force = 1'b0;

    // Single pair with OUT_READY held high
    bus.OUT_READY = 1'b1;
    accept(8'h3C, 8'hA5);
    chk("sp_in_ready_busy", bus.IN_READY, 0);
    chk("sp_no_early_valid", bus.OUT_VALID, 0);
    chk("sp_mux_a", bus.MUX_A, 8'h3C);
    chk("sp_mux_b", bus.MUX_B, 8'hA5);
    settle();
    chk("sp_a_valid", bus.OUT_VALID, 1);
    chk("sp_a_data", bus.OUT_DATA, 8'h3C);
    chk("sp_a_last", bus.OUT_LAST, 0);
    step();
    chk("sp_settle_b_valid", bus.OUT_VALID, 0);
    chk("sp_settle_b_s", bus.S, 1);
    settle();
    chk("sp_b_valid", bus.OUT_VALID, 1);
    chk("sp_b_data", bus.OUT_DATA, 8'hA5);
    chk("sp_b_last", bus.OUT_LAST, 1);
    step();
    chk("sp_ready_back", bus.IN_READY, 1);
    chk("sp_done_valid", bus.OUT_VALID, 0);
    chk("sp_done_s", bus.S, 0);

    // Backpressure in EMIT_A with an ignored new request
    bus.OUT_READY = 1'b0;
    accept(8'h3C, 8'hA5);
    settle();
    bus.A        = 8'h00;
    bus.B        = 8'hFF;
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", bus.OUT_VALID, 1);
      chk("bp_data", bus.OUT_DATA, 8'h3C);
      chk("bp_s", bus.S, 0);
      chk("bp_mux_a", bus.MUX_A, 8'h3C);
      chk("bp_mux_b", bus.MUX_B, 8'hA5);
      chk("bp_in_ready", bus.IN_READY, 0);
      step();
    end
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    step();
    settle();
    chk("bp_b_data", bus.OUT_DATA, 8'hA5);
    chk("bp_b_last", bus.OUT_LAST, 1);
    step();
    chk("bp_idle", bus.IN_READY, 1);

    // Reset during SETTLE_B
    accept(8'h11, 8'h22);
    settle();
    step();
    chk("mr_in_settle_b", bus.S, 1);
    #2;
    R = 1'b0;
    #1;
    chk("mr_out_valid", bus.OUT_VALID, 0);
    chk("mr_s", bus.S, 0);
    chk("mr_mux_a", bus.MUX_A, 0);
    chk("mr_mux_b", bus.MUX_B, 0);
    chk("mr_in_ready", bus.IN_READY, 1);
    @(negedge CLK);
    R = 1'b1;
    for (int i = 0; i < 2 * SETTLE + 2; i++) begin
      step();
      chk("mr_no_b_word", bus.OUT_VALID, 0);
    end

    // Back-to-back pairs
    exp_w = '{8'h01, 8'h80, 8'hFF, 8'h00};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
    bus.A         = 8'h01;
    bus.B         = 8'h80;
    bus.IN_VALID  = 1'b1;
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < 40 && (acc_cyc.size() < 2 || got_w.size() < 4); c++) begin
      hs_in = bus.IN_VALID && bus.IN_READY;
      if (bus.OUT_VALID && bus.OUT_READY) begin
        got_w.push_back(bus.OUT_DATA);
        got_l.push_back(bus.OUT_LAST);
      end
      step();
      if (hs_in) begin
        acc_cyc.push_back(c);
        if (acc_cyc.size() == 1) begin
          bus.A = 8'hFF;
          bus.B = 8'h00;
        end else begin
          bus.IN_VALID = 1'b0;
        end
      end
    end
    bus.IN_VALID = 1'b0;
    chk("b2b_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) chk("b2b_period", acc_cyc[1] - acc_cyc[0], PERIOD);
    chk("b2b_words", got_w.size(), 4);
    for (int i = 0; i < got_w.size() && i < 4; i++) begin
      chk($sformatf("b2b_word%0d", i), got_w[i], exp_w[i]);
      chk($sformatf("b2b_last%0d", i), got_l[i], exp_l[i]);
    end
    while (!bus.IN_READY) step();

    // Randomized traffic against a word-queue model
    glitch_en = 1'b1;
    have_acc  = 1'b0;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    prev_last = 1'b0;
    acc_a     = 8'h00;
    acc_b     = 8'h00;
    for (int c = 0; c < 400; c++) begin
      bus.IN_VALID  = 1'($urandom_range(0, 1));
      bus.A         = 8'($urandom);
      bus.B         = 8'($urandom);
      bus.OUT_READY = ($urandom_range(0, 3) != 0);
      y_rand        = 8'($urandom);
      if (prev_hold) begin
        chk("rnd_hold_valid", bus.OUT_VALID, 1);
        chk("rnd_hold_data", bus.OUT_DATA, prev_data);
        chk("rnd_hold_last", bus.OUT_LAST, prev_last);
      end
      if (have_acc) begin
        chk("rnd_mux_a", bus.MUX_A, acc_a);
        chk("rnd_mux_b", bus.MUX_B, acc_b);
      end
      chk("rnd_exclusive", bus.IN_READY && bus.OUT_VALID, 0);
      if (bus.OUT_VALID && bus.OUT_READY) begin
        chk("rnd_expected_word", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rnd_data", bus.OUT_DATA, e[7:0]);
          chk("rnd_last", bus.OUT_LAST, e[8]);
        end
      end
      prev_hold = bus.OUT_VALID && !bus.OUT_READY;
      prev_data = bus.OUT_DATA;
      prev_last = bus.OUT_LAST;
      if (bus.IN_VALID && bus.IN_READY) begin
        q.push_back({1'b0, bus.A});
        q.push_back({1'b1, bus.B});
        acc_a    = bus.A;
        acc_b    = bus.B;
        have_acc = 1'b1;
      end
      step();
    end
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < 50 && q.size() > 0; c++) begin
      if (bus.OUT_VALID) begin
        e = q.pop_front();
        chk("drain_data", bus.OUT_DATA, e[7:0]);
        chk("drain_last", bus.OUT_LAST, e[8]);
      end
      step();
    end
    chk("drain_empty", q.size(), 0);
    glitch_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
